perf_counter_arbiter: RTL and testbench
=======================================

// Module: perf_counter_arbiter
// PURPOSE
//  Shares the 8-section performance-counter control slave between NUM_REQ processor
//  cores of the multicore image pipeline. Each core issues GO/STOP/READ/RESET_ALL
//  commands per section. The block arbitrates round-robin, drives the counter slave,
//  and performs carry-safe 64-bit time reads (HI, LO, EVT, HI re-check). Sits between
//  core-side PIO/bridge logic and the counter's control slave.
// PARAMETERS
//  NUM_REQ   4   number of requesting cores (2..8)
// PORTS
//  clk              in   1         system clock
//  reset_n          in   1         synchronous, active-low reset
//  req_valid        in   NUM_REQ   per-core command request; held until req_ready
//  req_op           in   2*NUM_REQ per-core op: 0=GO 1=STOP 2=READ 3=RESET_ALL
//  req_section      in   3*NUM_REQ per-core section index 0..7
//  req_ready        out  NUM_REQ   one-hot, 1-cycle accept pulse
//  resp_valid       out  NUM_REQ   one-hot, 1-cycle completion pulse to accepted core
//  resp_time        out  64        section time count (valid with READ completion)
//  resp_events      out  32        section event count (valid with READ completion)
//  busy             out  1         high in any state other than IDLE
//  pc_address       out  5         counter slave word address
//  pc_write         out  1         counter slave write
//  pc_begintransfer out  1         counter slave begintransfer
//  pc_writedata     out  32        counter slave write data
//  pc_readdata      in   32        counter slave read data, registered: valid 1 cycle after address
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE, rr_ptr=0. All outputs 0, including
//    resp_time/resp_events. Any in-flight command is dropped with no resp_valid.
//  Addressing for section s: STOP/TIME_LO = 4s, GO/TIME_HI = 4s+1, EVENTS = 4s+2.
//  States: IDLE, WR, RD_HI, RD_LO, RD_EVT, RD_HI2, CHK, DONE.
//  IDLE: g = first index i>=rr_ptr (wrapping) with req_valid[i]. If none, stay in IDLE.
//    On a grant: req_ready[g]=1, latch op/section/g, rr_ptr <= (g+1)%NUM_REQ.
//    op 0/1/3 -> WR; op 2 -> RD_HI. pc_* outputs stay 0 in IDLE.
//  WR (1 cycle): pc_write=1, pc_begintransfer=1.
//    GO: addr 4s+1, wdata 0. STOP: addr 4s, wdata 0. RESET_ALL: addr 0, wdata 1
//    (the counter also clears section-0 enable). Next state: DONE.
//  Reads: pc_write=0, pc_begintransfer=1 for each address cycle.
//    RD_HI: addr 4s+1.
//    RD_LO: addr 4s; hi_q <= pc_readdata.
//    RD_EVT: addr 4s+2; lo_q <= pc_readdata.
//    RD_HI2: addr 4s+1; evt_q <= pc_readdata.
//    CHK: addr 0, begintransfer 0. If pc_readdata == hi_q -> DONE; else -> RD_HI
//    (full re-read; unbounded retry, needed only across a low-word wrap).
//  DONE (1 cycle): resp_valid[g]=1. For READ, resp_time <= {hi_q,lo_q} and
//    resp_events <= evt_q, both registered and visible in the DONE cycle; held
//    until the next READ completes. Non-READ ops leave resp_time/resp_events
//    unchanged. Next state: IDLE.
//  Latency, accept cycle = T: write op resp_valid at T+2; READ resp_valid at T+6
//    with no retry (+5 per retry). Next accept no earlier than the DONE+1 cycle.
//  One command in flight. req_valid changes from non-granted cores do not affect
//    the current command. A requester dropping req_valid before req_ready is legal;
//    it is simply not granted.
//  Simultaneous requests are resolved only by rr_ptr, never by op type.
// TESTING
//  1. Reset, then core0 GO s=2: req_ready[0] at T; pc_write, addr 9 at T+1; resp_valid[0] at T+2.
//  2. All 4 cores valid together, rr_ptr=0: grant order 0,1,2,3,0; each req_ready one-hot.
//  3. Counter model: s=1 time=0x0000_0005_0000_0010, events=3; core2 READ -> resp_time
//     0x0000000500000010, resp_events 3, at T+6.
//  4. Model time_lo=0xFFFFFFFE, running: READ sees HI mismatch -> retry; result
//     hi=1, lo small; resp_valid at T+11.
//  5. RESET_ALL from core3: addr 0, wdata 1, write pulse at T+1; model clears all counters.
//  6. reset_n low during RD_EVT: next cycle IDLE, all outputs 0, no resp_valid; rr_ptr=0.

Source files
------------

// File: rtl/perf_counter_arbiter_if.sv
// perf_counter_arbiter_if: core command/response handshake plus counter control-slave bus
//   req_valid/req_op/req_section  core -> arbiter command request (per-core slices)
//   req_ready/resp_valid          arbiter -> core one-hot accept/completion pulses
//   resp_time/resp_events         READ result, held until the next READ completes
//   busy                          arbiter not idle
//   pc_address/pc_write/pc_begintransfer/pc_writedata/pc_readdata  counter slave bus
interface perf_counter_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]   req_valid;
  logic [2*NUM_REQ-1:0] req_op;
  logic [3*NUM_REQ-1:0] req_section;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [63:0]          resp_time;
  logic [31:0]          resp_events;
  logic                 busy;
  logic [4:0]           pc_address;
  logic                 pc_write;
  logic                 pc_begintransfer;
  logic [31:0]          pc_writedata;
  logic [31:0]          pc_readdata;
  modport slave (
    input  req_valid, req_op, req_section, pc_readdata,
    output req_ready, resp_valid, resp_time, resp_events, busy,
           pc_address, pc_write, pc_begintransfer, pc_writedata
  );
  modport master (
    output req_valid, req_op, req_section, pc_readdata,
    input  req_ready, resp_valid, resp_time, resp_events, busy,
           pc_address, pc_write, pc_begintransfer, pc_writedata
  );
endinterface

// File: rtl/perf_counter_arbiter.sv
// perf_counter_arbiter: round-robin sharing of the performance-counter control slave between cores
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      perf_counter_arbiter_if.slave: core requests/responses and counter slave bus
module perf_counter_arbiter #(
  parameter int NUM_REQ = 4
) (
  input logic clk,
  input logic reset_n,
  perf_counter_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, WR, RD_HI, RD_LO, RD_EVT, RD_HI2, CHK, DONE} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, gidx, gnt_q;
  logic [2:0] sec_q, sec_sel;
  logic [1:0] op_sel;
  logic [31:0] hi_q, lo_q, evt_q;
  logic hit;
  // Scan downward so the lowest offset from rr_ptr is the one that sticks.
  always_comb begin
    hit = 1'b0;
    gidx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        hit = 1'b1;
        gidx = IW'((int'(rr_ptr) + k) % NUM_REQ);
      end
  end
  assign op_sel = bus.req_op[2*int'(gidx) +: 2];
  assign sec_sel = bus.req_section[3*int'(gidx) +: 3];
  // Accept is combinational so the grant lands in the same IDLE cycle the request is seen.
  assign bus.req_ready = (reset_n && state == IDLE && hit) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx : '0;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      gnt_q <= '0;
      sec_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      evt_q <= '0;
      bus.resp_valid <= '0;
      bus.resp_time <= '0;
      bus.resp_events <= '0;
      bus.busy <= 1'b0;
      bus.pc_address <= '0;
      bus.pc_write <= 1'b0;
      bus.pc_begintransfer <= 1'b0;
      bus.pc_writedata <= '0;
    end else begin
      bus.resp_valid <= '0;
      bus.pc_address <= '0;
      bus.pc_write <= 1'b0;
      bus.pc_begintransfer <= 1'b0;
      bus.pc_writedata <= '0;
      case (state)
        IDLE: if (hit) begin
          gnt_q <= gidx;
          sec_q <= sec_sel;
          rr_ptr <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          bus.busy <= 1'b1;
          bus.pc_begintransfer <= 1'b1;
          if (op_sel == 2'd2) begin
            state <= RD_HI;
            bus.pc_address <= {sec_sel, 2'd1};
          end else begin
            // GO hits 4s+1, STOP hits 4s, RESET_ALL writes 1 to word 0.
            state <= WR;
            bus.pc_write <= 1'b1;
            bus.pc_address <= (op_sel == 2'd3) ? 5'd0 : {sec_sel, 1'b0, op_sel == 2'd0};
            bus.pc_writedata <= {31'd0, op_sel == 2'd3};
          end
        end
        WR: begin
          state <= DONE;
          bus.resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
        end
        RD_HI: begin
          state <= RD_LO;
          bus.pc_begintransfer <= 1'b1;
          bus.pc_address <= {sec_q, 2'd0};
        end
        RD_LO: begin
          state <= RD_EVT;
          hi_q <= bus.pc_readdata;
          bus.pc_begintransfer <= 1'b1;
          bus.pc_address <= {sec_q, 2'd2};
        end
        RD_EVT: begin
          state <= RD_HI2;
          lo_q <= bus.pc_readdata;
          bus.pc_begintransfer <= 1'b1;
          bus.pc_address <= {sec_q, 2'd1};
        end
        RD_HI2: begin
          state <= CHK;
          evt_q <= bus.pc_readdata;
        end
        // A changed high word means the low word wrapped mid-read; start the whole read over.
        CHK: if (bus.pc_readdata == hi_q) begin
          state <= DONE;
          bus.resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
          bus.resp_time <= {hi_q, lo_q};
          bus.resp_events <= evt_q;
        end else begin
          state <= RD_HI;
          bus.pc_begintransfer <= 1'b1;
          bus.pc_address <= {sec_q, 2'd1};
        end
        DONE: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_perf_counter_arbiter.sv
// tb_perf_counter_arbiter: directed vector table plus multi-cycle read/retry/reset sequences
module tb_perf_counter_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  perf_counter_arbiter_if #(.NUM_REQ(4)) bus ();
  perf_counter_arbiter #(.NUM_REQ(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  logic [63:0] m_time [8];
  logic [31:0] m_evt [8];
  logic [7:0] m_run = '0;
  logic ld = 1'b0;
  logic [2:0] ld_sec = '0;
  logic [63:0] ld_time = '0;
  logic [31:0] ld_evt = '0;
  logic ld_run = 1'b0;
  initial for (int s = 0; s < 8; s++) begin
    m_time[s] = '0;
    m_evt[s] = '0;
  end
  always @(posedge clk) begin
    case (bus.pc_address[1:0])
      2'd0: bus.pc_readdata <= m_time[bus.pc_address[4:2]][31:0];
      2'd1: bus.pc_readdata <= m_time[bus.pc_address[4:2]][63:32];
      2'd2: bus.pc_readdata <= m_evt[bus.pc_address[4:2]];
      default: bus.pc_readdata <= '0;
    endcase
    for (int s = 0; s < 8; s++) if (m_run[s]) m_time[s] <= m_time[s] + 64'd1;
    if (bus.pc_write && bus.pc_begintransfer) begin
      if (bus.pc_address == 5'd0 && bus.pc_writedata[0]) begin
        for (int s = 0; s < 8; s++) begin
          m_time[s] <= '0;
          m_evt[s] <= '0;
        end
        m_run[0] <= 1'b0;
      end else if (bus.pc_address[1:0] == 2'd0) m_run[bus.pc_address[4:2]] <= 1'b0;
      else if (bus.pc_address[1:0] == 2'd1) m_run[bus.pc_address[4:2]] <= 1'b1;
    end
    if (ld) begin
      m_time[ld_sec] <= ld_time;
      m_evt[ld_sec] <= ld_evt;
      m_run[ld_sec] <= ld_run;
    end
  end
  typedef struct {
    logic [3:0] valid;
    logic [7:0] op;
    logic [11:0] sec;
    logic [3:0] ready;
    logic [4:0] addr;
    logic [31:0] wdata;
  } vec_t;
  vec_t tv [11];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic load(input int s, input logic [63:0] t, input logic [31:0] e, input logic r);
    @(negedge clk);
    ld = 1'b1;
    ld_sec = 3'(s);
    ld_time = t;
    ld_evt = e;
    ld_run = r;
    @(negedge clk);
    ld = 1'b0;
  endtask
  task automatic issue(input int c, input logic [1:0] op, input logic [2:0] sec, output int lat);
    @(negedge clk);
    bus.req_valid = '0;
    bus.req_valid[c] = 1'b1;
    bus.req_op[2*c +: 2] = op;
    bus.req_section[3*c +: 3] = sec;
    #1 chk("issue_ready", 64'(bus.req_ready), 64'(4'b1 << c));
    @(negedge clk);
    bus.req_valid = '0;
    lat = 1;
    while (bus.resp_valid == '0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("issue_resp", 64'(bus.resp_valid), 64'(4'b1 << c));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int lat;
    tv[0]  = '{4'b0001, 8'h44, 12'h3EA, 4'b0001, 5'd9,  32'd0};
    tv[1]  = '{4'b1000, 8'h44, 12'hFEA, 4'b1000, 5'd28, 32'd0};
    tv[2]  = '{4'b1111, 8'h44, 12'h3EA, 4'b0001, 5'd9,  32'd0};
    tv[3]  = '{4'b1111, 8'h44, 12'h3EA, 4'b0010, 5'd20, 32'd0};
    tv[4]  = '{4'b1111, 8'h44, 12'h3EA, 4'b0100, 5'd29, 32'd0};
    tv[5]  = '{4'b1111, 8'h44, 12'h3EA, 4'b1000, 5'd4,  32'd0};
    tv[6]  = '{4'b1111, 8'h44, 12'h3EA, 4'b0001, 5'd9,  32'd0};
    tv[7]  = '{4'b0101, 8'h44, 12'h3EA, 4'b0100, 5'd29, 32'd0};
    tv[8]  = '{4'b0011, 8'h44, 12'h3EA, 4'b0001, 5'd9,  32'd0};
    tv[9]  = '{4'b1000, 8'hC4, 12'h3EA, 4'b1000, 5'd0,  32'd1};
    tv[10] = '{4'b0010, 8'h44, 12'h3C2, 4'b0010, 5'd0,  32'd0};
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_section = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_pc", 64'({bus.pc_write, bus.pc_begintransfer, bus.pc_address, bus.pc_writedata}), 64'd0);
    chk("rst_resp", {bus.resp_valid, bus.resp_events}, 64'd0);
    chk("rst_time", bus.resp_time, 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.req_valid = tv[i].valid;
      bus.req_op = tv[i].op;
      bus.req_section = tv[i].sec;
      #1 chk($sformatf("v%0d_ready", i), 64'(bus.req_ready), 64'(tv[i].ready));
      @(negedge clk);
      bus.req_valid = '0;
      chk($sformatf("v%0d_wr_bt_busy", i), 64'({bus.pc_write, bus.pc_begintransfer, bus.busy}), 64'd7);
      chk($sformatf("v%0d_addr", i), 64'(bus.pc_address), 64'(tv[i].addr));
      chk($sformatf("v%0d_wdata", i), 64'(bus.pc_writedata), 64'(tv[i].wdata));
      @(negedge clk);
      chk($sformatf("v%0d_resp", i), 64'({bus.resp_valid, bus.pc_write}), 64'({tv[i].ready, 1'b0}));
    end
    load(1, 64'h0000_0005_0000_0010, 32'd3, 1'b0);
    issue(2, 2'd2, 3'd1, lat);
    chk("read_latency", 64'(lat), 64'd6);
    chk("read_time", bus.resp_time, 64'h0000_0005_0000_0010);
    chk("read_events", 64'(bus.resp_events), 64'd3);
    @(negedge clk);
    chk("read_hold", bus.resp_time, 64'h0000_0005_0000_0010);
    load(3, 64'h0000_0000_FFFF_FFFC, 32'd7, 1'b1);
    issue(1, 2'd2, 3'd3, lat);
    chk("retry_latency", 64'(lat), 64'd11);
    chk("retry_hi", 64'(bus.resp_time[63:32]), 64'd1);
    chk("retry_lo_small", 64'(bus.resp_time[31:0] < 32'd16), 64'd1);
    chk("retry_events", 64'(bus.resp_events), 64'd7);
    @(negedge clk);
    bus.req_valid = 4'b0001;
    bus.req_op = 8'h46;
    bus.req_section = 12'h3EB;
    #1 chk("rst6_accept", 64'(bus.req_ready), 64'd1);
    repeat (3) @(negedge clk);
    bus.req_valid = '0;
    chk("rst6_in_evt", 64'({bus.pc_begintransfer, bus.pc_address}), 64'({1'b1, 5'd14}));
    reset_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_op = 8'h44;
    bus.req_section = 12'h3EA;
    @(negedge clk);
    chk("rst6_busy", 64'(bus.busy), 64'd0);
    chk("rst6_pc", 64'({bus.pc_write, bus.pc_begintransfer, bus.pc_address, bus.pc_writedata}), 64'd0);
    chk("rst6_ready_resp", 64'({bus.req_ready, bus.resp_valid}), 64'd0);
    chk("rst6_time", bus.resp_time, 64'd0);
    chk("rst6_events", 64'(bus.resp_events), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rst6_rr_ptr", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = '0;
    chk("rst6_go_addr", 64'(bus.pc_address), 64'd9);
    @(negedge clk);
    chk("rst6_go_resp", 64'(bus.resp_valid), 64'd1);
    issue(3, 2'd3, 3'd5, lat);
    chk("resetall_latency", 64'(lat), 64'd2);
    load(1, 64'h0000_0005_0000_0010, 32'd3, 1'b0);
    issue(3, 2'd3, 3'd0, lat);
    issue(0, 2'd2, 3'd1, lat);
    chk("resetall_read_lat", 64'(lat), 64'd6);
    chk("resetall_read_time", bus.resp_time, 64'd0);
    chk("resetall_read_evt", 64'(bus.resp_events), 64'd0);
    @(negedge clk);
    chk("final_idle", 64'({bus.busy, bus.resp_valid}), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
